// File: rtl/sram_req_arbiter_pkg.sv
// Shared constants for the instruction/data sram request arbiter.
package sram_req_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SIZE_W = 2;
   localparam int STRB_W = 4;

   // Owner tag values stored in the outstanding-request FIFO
   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   // Instruction fetches are always full-word reads
   localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/sram_req_arbiter_owner_tag_fifo.sv
// One-bit-wide FIFO remembering which requester owns each accepted,
// not-yet-answered memory request, oldest at the head.
module owner_tag_fifo #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic push,
   input  logic push_tag,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic head_tag
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] tags;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign head_tag = tags[head];
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tags  <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            tags[tail] <= push_tag;
            tail       <= tail + PTR_W'(1);
         end
         if (do_pop) begin
            head <= head + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_req_arbiter.sv
// Merges the fetch and load/store sram-like ports onto one downstream
// memory port. Data side has priority, a grant is held until accepted,
// and responses are steered back in issue order via an owner-tag FIFO.
module sram_req_arbiter
   import sram_req_arbiter_pkg::*;
#(
   parameter int OUTST_DEPTH = 2
) (
   input  logic              clk,
   input  logic              resetn,

   input  logic              inst_sram_req,
   input  logic [ADDR_W-1:0] inst_sram_addr,
   output logic              inst_sram_addr_ok,
   output logic              inst_sram_data_ok,
   output logic [DATA_W-1:0] inst_sram_rdata,

   input  logic              data_sram_req,
   input  logic              data_sram_wr,
   input  logic [SIZE_W-1:0] data_sram_size,
   input  logic [ADDR_W-1:0] data_sram_addr,
   input  logic [STRB_W-1:0] data_sram_wstrb,
   input  logic [DATA_W-1:0] data_sram_wdata,
   output logic              data_sram_addr_ok,
   output logic              data_sram_data_ok,
   output logic [DATA_W-1:0] data_sram_rdata,

   output logic              mem_req,
   output logic              mem_wr,
   output logic [SIZE_W-1:0] mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [STRB_W-1:0] mem_wstrb,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic lock_vld;
   logic lock_owner;
   logic owner_vld;
   logic owner;
   logic owner_req;
   logic fifo_full;
   logic fifo_empty;
   logic head_tag;
   logic accept;
   logic pop;

   // Pick the requester driving the memory port this cycle
   always_comb begin
      owner_vld = 1'b0;
      owner     = OWNER_INST;
      if (lock_vld) begin
         owner_vld = 1'b1;
         owner     = lock_owner;
      end else if (data_sram_req) begin
         owner_vld = 1'b1;
         owner     = OWNER_DATA;
      end else if (inst_sram_req) begin
         owner_vld = 1'b1;
         owner     = OWNER_INST;
      end
   end

   assign owner_req = owner_vld & ((owner == OWNER_DATA) ? data_sram_req : inst_sram_req);
   assign mem_req   = owner_req & ~fifo_full;
   assign accept    = mem_req & mem_addr_ok;

   // Steer the request fields from the owner; fetches are fixed word reads
   always_comb begin
      mem_wr    = 1'b0;
      mem_size  = '0;
      mem_addr  = '0;
      mem_wstrb = '0;
      mem_wdata = '0;
      if (owner_vld) begin
         if (owner == OWNER_DATA) begin
            mem_wr    = data_sram_wr;
            mem_size  = data_sram_size;
            mem_addr  = data_sram_addr;
            mem_wstrb = data_sram_wstrb;
            mem_wdata = data_sram_wdata;
         end else begin
            mem_size  = SIZE_WORD;
            mem_addr  = inst_sram_addr;
         end
      end
   end

   assign inst_sram_addr_ok = accept & (owner == OWNER_INST);
   assign data_sram_addr_ok = accept & (owner == OWNER_DATA);

   // Hold the grant on a presented-but-unaccepted request until it is taken
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_vld   <= 1'b0;
         lock_owner <= OWNER_INST;
      end else if (mem_req && !mem_addr_ok) begin
         lock_vld   <= 1'b1;
         lock_owner <= owner;
      end else if (accept) begin
         lock_vld   <= 1'b0;
      end
   end

   // Responses with nothing outstanding are dropped
   assign pop = mem_data_ok & ~fifo_empty;

   owner_tag_fifo #(
      .DEPTH (OUTST_DEPTH)
   ) u_tag_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .push     (accept),
      .push_tag (owner),
      .pop      (pop),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head_tag (head_tag)
   );

   assign inst_sram_data_ok = pop & (head_tag == OWNER_INST);
   assign data_sram_data_ok = pop & (head_tag == OWNER_DATA);
   assign inst_sram_rdata   = mem_rdata;
   assign data_sram_rdata   = mem_rdata;

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one sram-like memory port (req/addr_ok/data_ok protocol) between the core's instruction-fetch requester and its load/store requester.
- Sits between the core's inst_sram/data_sram interfaces and the single downstream memory/bridge port.
- Grants by fixed priority, holds a grant stable while waiting for addr_ok, and tracks accepted-but-unanswered requests in an owner-tag FIFO.
- Each data_ok/rdata is routed back to the requester that issued it, in issue order.

Parameters:
- OUTST_DEPTH, 2: maximum accepted-but-unanswered requests (owner-tag FIFO depth, power of two, >=2).

Ports:
- clk  in  1  single clock, all state on rising edge
- resetn  in  1  reset, asynchronous, active-low
- inst_sram_req  in  1  fetch request valid (always a word read)
- inst_sram_addr  in  32  fetch address
- inst_sram_addr_ok  out  1  fetch request accepted this cycle
- inst_sram_data_ok  out  1  fetch response valid this cycle
- inst_sram_rdata  out  32  fetch response data
- data_sram_req  in  1  load/store request valid
- data_sram_wr  in  1  1=store, 0=load
- data_sram_size  in  2  0=byte, 1=half, 2=word
- data_sram_addr  in  32  load/store address
- data_sram_wstrb  in  4  store byte enables
- data_sram_wdata  in  32  store data
- data_sram_addr_ok  out  1  load/store request accepted this cycle
- data_sram_data_ok  out  1  load/store response (store completion or load data) valid
- data_sram_rdata  out  32  load response data
- mem_req  out  1  merged request valid
- mem_wr  out  1  merged write flag
- mem_size  out  2  merged size
- mem_addr  out  32  merged address
- mem_wstrb  out  4  merged byte enables
- mem_wdata  out  32  merged write data
- mem_addr_ok  in  1  downstream accepted request
- mem_data_ok  in  1  downstream response valid
- mem_rdata  in  32  downstream response data

Behaviour:
- State:
  - tag FIFO: OUTST_DEPTH entries x 1 bit (0=inst, 1=data), with head/tail pointers and count 0..OUTST_DEPTH.
  - lock_vld (1 bit) and lock_owner (1 bit).
  - All state resets asynchronously to 0 when resetn=0.
- Owner select (combinational):
  - lock_vld=1: owner=lock_owner.
  - Else data_sram_req=1: owner=data.
  - Else inst_sram_req=1: owner=inst.
  - Else none.
- full = (count==OUTST_DEPTH).
- mem_req = owner's req & ~full.
- mem_* fields mux from the owner:
  - inst: wr=0, size=2'b10, wstrb=0, wdata=0.
  - none: all fields 0.
- Requester addr_ok = mem_addr_ok & mem_req & (owner is that requester); the other requester's addr_ok is 0.
- Lock:
  - mem_req=1 & mem_addr_ok=0 at a clock edge: set lock_vld=1, lock_owner=owner.
  - mem_addr_ok=1 with mem_req=1: lock_vld=0.
  - A request issued downstream is therefore never switched or dropped before acceptance.
  - Lock persists while full (mem_req low, owner req still high).
- Push: mem_req & mem_addr_ok writes the owner tag at tail; tail wraps modulo OUTST_DEPTH.
- Pop: mem_data_ok & count!=0 pops head; head wraps modulo OUTST_DEPTH.
  - Routing: inst_sram_data_ok = pop & (head tag==0); data_sram_data_ok = pop & (head tag==1).
  - inst_sram_rdata and data_sram_rdata both carry mem_rdata unconditionally.
- Simultaneous push and pop: count unchanged, both pointers advance.
- full is evaluated from registered count; a pop in the same cycle does not unblock a new request (one bubble accepted).
- mem_data_ok with count==0 is ignored: no data_ok raised on either port, no state change.
- Latency: request path and response path are combinational, zero added cycles. Requests are accepted at most one per cycle.
- During and immediately after reset:
  - mem_req follows inputs; count=0, lock_vld=0.
  - Both data_ok outputs are 0.
  - Responses outstanding before reset are discarded; downstream must be reset together with this block.

Decomposition:
- Shared package/header holds the constants OWNER_INST=1'b0, OWNER_DATA=1'b1, SIZE_WORD=2'b10, plus the port-field widths.
- One sub-module, owner_tag_fifo (1-bit wide, OUTST_DEPTH deep, push/pop/full/empty/head_tag), with the same clk/resetn semantics.

Test Plan:
- Same-cycle priority: inst req addr 0x1c000000 and data load addr 0x00001000 in the same cycle, mem_addr_ok=1 -> data addr_ok cycle 0, inst addr_ok cycle 1. Two mem_data_ok with rdata 0xAAAA0000 then 0x12345678 -> data_sram_data_ok on the first, inst_sram_data_ok on the second.
- Lock: inst req at cycle 0, mem_addr_ok=0 for cycles 0-1 and 1 at cycle 2, data req rises at cycle 1 -> mem_addr stays 0x1c000000 through cycle 2, inst addr_ok at cycle 2, data granted at cycle 3.
- Full: OUTST_DEPTH=2, two accepted requests, no data_ok -> third inst req sees mem_req=0 and inst addr_ok=0. One mem_data_ok pops; the third request is accepted the following cycle.
- Store pass-through: data wr=1, size=1, addr 0x00002002, wstrb=4'b1100, wdata 0xBEEF0000 -> mem_* fields identical; the later mem_data_ok asserts data_sram_data_ok only.
- Spurious and reset: mem_data_ok with empty FIFO -> both data_ok stay 0. Asserting resetn=0 mid-cycle with one request outstanding and lock set -> count=0 and lock_vld=0 immediately, with no clock edge needed.
